// File: rtl/alu_issue_if.sv
// Instruction handshake and ALU operand/result bus for the alu_issue stage.
// The master side is whoever feeds instructions and hosts the ALU; the slave
// side is the issue stage itself.
interface alu_issue_if #(
   parameter int WIDTH = 4
);
   logic [7:0]       instr;
   logic             instr_valid;
   logic             instr_ready;
   logic [WIDTH-1:0] ALU_A;
   logic [WIDTH-1:0] ALU_B;
   logic             alu_sel;
   logic [WIDTH-1:0] ALU_RES;

   modport master (
      output instr,
      output instr_valid,
      output ALU_RES,
      input  instr_ready,
      input  ALU_A,
      input  ALU_B,
      input  alu_sel
   );

   modport slave (
      input  instr,
      input  instr_valid,
      input  ALU_RES,
      output instr_ready,
      output ALU_A,
      output ALU_B,
      output alu_sel
   );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback stage wrapped around a combinational 4-bit ADD/NAND ALU.
// Holds a 4-entry register file, registers ALU operands at accept so the ALU
// gets a full cycle to settle, then writes the result back on the next edge.
module alu_issue #(
   parameter int WIDTH     = 4,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_if.slave       bus,
   output logic             done,
   output logic             Z,
   input  logic [1:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [1:0] OP_LDI = 2'b10;

   typedef enum logic {
      IDLE,
      EXEC
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_ready;
   logic             w_accept;
   logic             w_isAlu;

   logic [WIDTH-1:0] r_regs [4];
   logic [WIDTH-1:0] r_aluA;
   logic [WIDTH-1:0] r_aluB;
   logic             r_aluSel;
   logic [1:0]       r_rd;
   logic             r_done;
   logic             r_z;

   logic [1:0]       w_op;
   logic [1:0]       w_rd;
   logic [1:0]       w_rs1;
   logic [1:0]       w_rs2;
   logic [WIDTH-1:0] w_imm;

   assign w_op  = bus.instr[7:6];
   assign w_rd  = bus.instr[5:4];
   assign w_rs1 = bus.instr[3:2];
   assign w_rs2 = bus.instr[1:0];
   assign w_imm = WIDTH'(bus.instr[3:0]);

   // State register: EXEC always lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and handshake decode; ADD/NAND (op[1]==0) go to EXEC, LDI/NOP retire at once.
   always_comb begin
      w_next   = r_state;
      w_ready  = 1'b0;
      w_accept = 1'b0;
      w_isAlu  = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (bus.instr_valid) begin
               w_accept = 1'b1;
               if (!w_op[1]) begin
                  w_isAlu = 1'b1;
                  w_next  = EXEC;
               end
            end
         end
         EXEC: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Register file: LDI writes at accept, ALU result writes at the closing edge of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= WIDTH'(RESET_VAL);
         end
      end else if (r_state == EXEC) begin
         r_regs[r_rd] <= bus.ALU_RES;
      end else if (w_accept && (w_op == OP_LDI)) begin
         r_regs[w_rd] <= w_imm;
      end
   end

   // Operand capture at ALU accept; values are held afterwards so the ALU input stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aluA   <= '0;
         r_aluB   <= '0;
         r_aluSel <= 1'b0;
         r_rd     <= 2'b00;
      end else if (w_isAlu) begin
         r_aluA   <= r_regs[w_rs1];
         r_aluB   <= r_regs[w_rs2];
         r_aluSel <= w_op[0];
         r_rd     <= w_rd;
      end
   end

   // Retire pulse and zero flag; only ALU writebacks touch Z.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
         r_z    <= 1'b0;
      end else begin
         r_done <= (w_accept && !w_isAlu) || (r_state == EXEC);
         if (r_state == EXEC) begin
            r_z <= (bus.ALU_RES == '0);
         end
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.ALU_A       = r_aluA;
   assign bus.ALU_B       = r_aluB;
   assign bus.alu_sel     = r_aluSel;
   assign done            = r_done;
   assign Z               = r_z;
   assign dbg_data        = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a driver issues instructions and pushes the
// expected retirement, a monitor pops and checks on every done pulse.
module tb_alu_issue;

   localparam int WIDTH = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       done;
   logic       Z;
   logic [1:0] dbgAddr;
   logic [1:0] mainAddr = 2'd0;
   logic [1:0] monAddr  = 2'd0;
   logic       useMon   = 1'b1;
   logic [3:0] dbgData;

   always #5 clk = ~clk;

   alu_issue_if #(.WIDTH(WIDTH)) ifc ();

   // Behavioural ALU hosted by the bench
   assign ifc.ALU_RES = ifc.alu_sel ? ~(ifc.ALU_A & ifc.ALU_B) : (ifc.ALU_A + ifc.ALU_B);
   assign dbgAddr     = useMon ? monAddr : mainAddr;

   alu_issue #(.WIDTH(WIDTH), .RESET_VAL(0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (ifc),
      .done     (done),
      .Z        (Z),
      .dbg_addr (dbgAddr),
      .dbg_data (dbgData)
   );

   typedef struct {
      logic [1:0] rd;
      logic       writes;
      logic [3:0] val;
      logic       z;
      int         lat;
      int         acceptCycle;
   } exp_t;

   exp_t       sbQ[$];
   int         nChecks = 0;
   int         nErrors = 0;
   int         cycle   = 0;
   int         modelR[4];
   logic       modelZ;
   logic [3:0] expA;
   logic [3:0] expB;
   logic       expSel;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic void check(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cycle);
      end
   endfunction

   // Drive one instruction, wait for acceptance, and record what its retirement must look like
   task automatic applyStimulus(input logic [7:0] ins);
      int   guard = 0;
      int   op, rd, rs1, rs2, res;
      exp_t e;
      @(negedge clk);
      ifc.instr       = ins;
      ifc.instr_valid = 1'b1;
      while (!ifc.instr_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!ifc.instr_ready) begin
         check("readyTimeout", 0, 1);
         ifc.instr_valid = 1'b0;
         return;
      end
      op  = int'(ins[7:6]);
      rd  = int'(ins[5:4]);
      rs1 = int'(ins[3:2]);
      rs2 = int'(ins[1:0]);
      res = 0;
      case (op)
         0: res = (modelR[rs1] + modelR[rs2]) % 16;
         1: res = 15 - (modelR[rs1] & modelR[rs2]);
         2: res = int'(ins[3:0]);
         default: res = 0;
      endcase
      if (op < 2) begin
         expA   = 4'(modelR[rs1]);
         expB   = 4'(modelR[rs2]);
         expSel = (op == 1);
         modelZ = (res == 0);
      end
      if (op != 3) modelR[rd] = res;
      e.rd          = 2'(rd);
      e.writes      = (op != 3);
      e.val         = 4'(res);
      e.z           = modelZ;
      e.lat         = (op < 2) ? 1 : 0;
      e.acceptCycle = cycle + 1;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      ifc.instr       = 8'($urandom);
   endtask

   task automatic checkOutput(input string tag);
      check({tag, "_ready"}, int'(ifc.instr_ready), 1);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_Z"}, int'(Z), 0);
      check({tag, "_aluA"}, int'(ifc.ALU_A), 0);
      check({tag, "_aluB"}, int'(ifc.ALU_B), 0);
      check({tag, "_aluSel"}, int'(ifc.alu_sel), 0);
      useMon = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mainAddr = 2'(i);
         #1;
         check({tag, "_reg"}, int'(dbgData), 0);
      end
      useMon = 1'b1;
   endtask

   // Asynchronous reset in the cycle after the last accept, checked before any clock edge
   task automatic applyReset(input string tag);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput(tag);
      for (int i = 0; i < 4; i++) modelR[i] = 0;
      modelZ = 1'b0;
      sbQ.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: ALU inputs stable during EXEC, and each done pulse retires the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (!ifc.instr_ready) begin
               check("execAluA", int'(ifc.ALU_A), int'(expA));
               check("execAluB", int'(ifc.ALU_B), int'(expB));
               check("execAluSel", int'(ifc.alu_sel), int'(expSel));
            end
            if (done) begin
               if (sbQ.size() == 0) begin
                  check("unexpectedDone", 1, 0);
               end else begin
                  e = sbQ.pop_front();
                  monAddr = e.rd;
                  #1;
                  if (e.writes) check("regWrite", int'(dbgData), int'(e.val));
                  check("zFlag", int'(Z), int'(e.z));
                  check("latency", cycle - e.acceptCycle, e.lat);
               end
            end
         end
      end
   end

   initial begin
      int guard;
      ifc.instr       = 8'h00;
      ifc.instr_valid = 1'b0;
      for (int i = 0; i < 4; i++) modelR[i] = 0;
      modelZ = 1'b0;
      expA   = 4'h0;
      expB   = 4'h0;
      expSel = 1'b0;

      repeat (2) @(negedge clk);
      #2;
      checkOutput("initReset");
      @(negedge clk);
      rst_n = 1'b1;

      // Overflow wraps: 9 + 9 = 2
      applyStimulus(8'b10_01_1001);
      applyStimulus(8'b10_10_1001);
      applyStimulus(8'b00_11_01_10);

      // NAND of all-ones gives zero and sets Z
      applyStimulus(8'b10_00_1111);
      applyStimulus(8'b01_00_00_00);

      // Mid-run reset while an LDI is retiring and Z is set
      applyStimulus(8'b10_11_0101);
      applyReset("midReset");

      // Self-referencing ADD, then a dependent ADD held valid through EXEC
      applyStimulus(8'b10_01_0011);
      applyStimulus(8'b00_01_01_01);
      applyStimulus(8'b00_10_01_01);
      applyStimulus(8'b11_00_0000);

      // Reset during EXEC aborts the writeback
      applyStimulus(8'b10_10_0101);
      applyStimulus(8'b00_10_00_01);
      applyReset("execReset");

      // Randomized traffic with random idle gaps
      for (int n = 0; n < 300; n++) begin
         applyStimulus(8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      guard = 0;
      while (sbQ.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("drainPending", sbQ.size(), 0);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
